// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. a 2-entry FIFO of long-latency results.
// Optional starvation guard enabled by defining REGFILE_ARB_STARVE_GUARD_EN.
module regfile_write_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipeWriteEnable,
    input  logic [4:0]  pipeWriteIndex,
    input  logic [31:0] pipeWriteData,
    input  logic        longIssueValid,
    input  logic [4:0]  longIssueIndex,
    input  logic        longResultValid,
    input  logic [4:0]  longResultIndex,
    input  logic [31:0] longResultData,
    output logic        longResultReady,
    output logic        rfShouldWrite,
    output logic [4:0]  rfWriteIndex,
    output logic [31:0] rfWriteData,
    output logic [31:0] busyMask,
    output logic        pipeStall,
    output logic [1:0]  bufferCount
);

    // Handshake: a long result transfers on a rising edge where longResultValid
    // and longResultReady are both high; ready depends on FIFO occupancy only.

    logic [4:0]  fifo_idx  [2];
    logic [31:0] fifo_data [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;
    logic [4:0]  head_idx;
    logic [31:0] head_data;
    logic        fifo_valid;
    logic        pipe_present;
    logic        pipe_win;
    logic        force_head;
    logic        drain;
    logic        accept;
    logic [31:0] busy_next;

    assign head_idx        = fifo_idx[rd_ptr];
    assign head_data       = fifo_data[rd_ptr];
    assign fifo_valid      = (count != 2'd0);
    assign longResultReady = (count != 2'd2);
    assign bufferCount     = count;
    assign accept          = longResultValid && longResultReady;
    assign pipe_present    = pipeWriteEnable && (pipeWriteIndex != 5'd0);

`ifdef REGFILE_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] starve_cnt;

    assign force_head = fifo_valid && (starve_cnt == CW'(STARVE_LIMIT));

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (drain || !fifo_valid) begin
            starve_cnt <= '0;
        end else if (starve_cnt != CW'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    logic unused_starve_limit;
    assign unused_starve_limit = (STARVE_LIMIT > 0);
    assign force_head = 1'b0;
`endif

    // An index-0 pipe write is treated as absent, so the head may drain under it.
    assign pipe_win  = pipe_present && !force_head;
    assign pipeStall = pipe_present && force_head;
    assign drain     = fifo_valid && (!pipe_present || force_head);

    always_comb begin
        rfShouldWrite = 1'b0;
        rfWriteIndex  = 5'd0;
        rfWriteData   = 32'd0;
        if (pipe_win) begin
            rfShouldWrite = 1'b1;
            rfWriteIndex  = pipeWriteIndex;
            rfWriteData   = pipeWriteData;
        end else if (drain && (head_idx != 5'd0)) begin
            rfShouldWrite = 1'b1;
            rfWriteIndex  = head_idx;
            rfWriteData   = head_data;
        end
    end

    // Clear first, then set, so a same-cycle issue to the draining index wins.
    always_comb begin
        busy_next = busyMask;
        if (drain) begin
            busy_next[head_idx] = 1'b0;
        end
        if (longIssueValid && (longIssueIndex != 5'd0)) begin
            busy_next[longIssueIndex] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !reset) begin
            fifo_idx[wr_ptr]  <= longResultIndex;
            fifo_data[wr_ptr] <= longResultData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
            busyMask <= 32'd0;
        end else begin
            if (accept) begin
                wr_ptr <= ~wr_ptr;
            end
            if (drain) begin
                rd_ptr <= ~rd_ptr;
            end
            count    <= count + {1'b0, accept} - {1'b0, drain};
            busyMask <= busy_next;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter; long-result writes are tracked in an expected queue.
// Covers the starvation guard scenario when REGFILE_ARB_STARVE_GUARD_EN is defined.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipeWriteEnable;
    logic [4:0]  pipeWriteIndex;
    logic [31:0] pipeWriteData;
    logic        longIssueValid;
    logic [4:0]  longIssueIndex;
    logic        longResultValid;
    logic [4:0]  longResultIndex;
    logic [31:0] longResultData;
    logic        longResultReady;
    logic        rfShouldWrite;
    logic [4:0]  rfWriteIndex;
    logic [31:0] rfWriteData;
    logic [31:0] busyMask;
    logic        pipeStall;
    logic [1:0]  bufferCount;

    int checks   = 0;
    int failures = 0;
    logic [36:0] exp_q[$];

    always #5 clk = ~clk;

    regfile_write_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .pipeWriteEnable (pipeWriteEnable),
        .pipeWriteIndex  (pipeWriteIndex),
        .pipeWriteData   (pipeWriteData),
        .longIssueValid  (longIssueValid),
        .longIssueIndex  (longIssueIndex),
        .longResultValid (longResultValid),
        .longResultIndex (longResultIndex),
        .longResultData  (longResultData),
        .longResultReady (longResultReady),
        .rfShouldWrite   (rfShouldWrite),
        .rfWriteIndex    (rfWriteIndex),
        .rfWriteData     (rfWriteData),
        .busyMask        (busyMask),
        .pipeStall       (pipeStall),
        .bufferCount     (bufferCount)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        pipeWriteEnable = 1'b0;
        pipeWriteIndex  = 5'd0;
        pipeWriteData   = 32'd0;
        longIssueValid  = 1'b0;
        longIssueIndex  = 5'd0;
        longResultValid = 1'b0;
        longResultIndex = 5'd0;
        longResultData  = 32'd0;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    // Called at the negedge: pipe writes are checked directly, any other write pops the queue.
    task automatic sb_check(input logic exp_stall);
        logic        present;
        logic [36:0] e;
        present = pipeWriteEnable && (pipeWriteIndex != 5'd0);
        chk("pipe_stall", {63'd0, pipeStall}, {63'd0, exp_stall});
        if (present && !exp_stall) begin
            chk("pipe_we",   {63'd0, rfShouldWrite}, 64'd1);
            chk("pipe_idx",  {59'd0, rfWriteIndex}, {59'd0, pipeWriteIndex});
            chk("pipe_data", {32'd0, rfWriteData}, {32'd0, pipeWriteData});
        end else if (rfShouldWrite) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {63'd0, rfShouldWrite}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("long_idx",  {59'd0, rfWriteIndex}, {59'd0, e[36:32]});
                chk("long_data", {32'd0, rfWriteData}, {32'd0, e[31:0]});
            end
        end
    endtask

    task automatic offer(input logic [4:0] idx, input logic [31:0] data);
        longResultValid = 1'b1;
        longResultIndex = idx;
        longResultData  = data;
    endtask

    initial begin
        logic [31:0] d;
        // Reset cycle with issue and result presented: both must be ignored.
        idle_inputs();
        reset = 1'b1;
        longIssueValid = 1'b1;
        longIssueIndex = 5'd9;
        offer(5'd9, 32'h1234);
        advance();
        reset = 1'b0;
        idle_inputs();
        settle();
        chk("rst_count", {62'd0, bufferCount}, 64'd0);
        chk("rst_ready", {63'd0, longResultReady}, 64'd1);
        chk("rst_busy",  {32'd0, busyMask}, 64'd0);
        chk("rst_we",    {63'd0, rfShouldWrite}, 64'd0);
        chk("rst_stall", {63'd0, pipeStall}, 64'd0);
        chk("idle_idx",  {59'd0, rfWriteIndex}, 64'd0);
        chk("idle_data", {32'd0, rfWriteData}, 64'd0);
        advance();

        // Issue x5, then its result one cycle later; written the cycle after accept.
        longIssueValid = 1'b1;
        longIssueIndex = 5'd5;
        settle(); sb_check(1'b0); advance();
        idle_inputs();
        offer(5'd5, 32'hDEADBEEF);
        settle();
        chk("x5_busy_set", {32'd0, busyMask}, 64'h20);
        chk("x5_ready", {63'd0, longResultReady}, 64'd1);
        chk("x5_no_same_cycle_write", {63'd0, rfShouldWrite}, 64'd0);
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        sb_check(1'b0); advance();
        idle_inputs();
        settle();
        chk("x5_count1", {62'd0, bufferCount}, 64'd1);
        chk("x5_we", {63'd0, rfShouldWrite}, 64'd1);
        sb_check(1'b0); advance();
        settle();
        chk("x5_busy_clr", {32'd0, busyMask}, 64'd0);
        chk("x5_count0", {62'd0, bufferCount}, 64'd0);
        chk("x5_idle_we", {63'd0, rfShouldWrite}, 64'd0);
        advance();

        // Back-to-back results with pipe idle: accept and drain in the same cycle.
        d = $urandom; offer(5'd13, d); exp_q.push_back({5'd13, d});
        settle(); sb_check(1'b0); advance();
        d = $urandom; offer(5'd14, d); exp_q.push_back({5'd14, d});
        settle(); sb_check(1'b0); advance();
        idle_inputs();
        settle();
        chk("acc_drain_count", {62'd0, bufferCount}, 64'd1);
        sb_check(1'b0); advance();

`ifndef REGFILE_ARB_STARVE_GUARD_EN
        // Pipe writes x3 every cycle; third result sees ready low, pipe never delayed.
        pipeWriteEnable = 1'b1;
        pipeWriteIndex  = 5'd3;
        for (int i = 0; i < 3; i++) begin
            pipeWriteData = $urandom;
            d = $urandom;
            offer(5'd10 + 5'(i), d);
            settle();
            chk("full_count", {62'd0, bufferCount}, 64'(i));
            chk("full_ready", {63'd0, longResultReady}, (i < 2) ? 64'd1 : 64'd0);
            if (i < 2) exp_q.push_back({5'd10 + 5'(i), d});
            sb_check(1'b0); advance();
        end
        longResultValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pipeWriteData = $urandom;
            settle();
            chk("blocked_count", {62'd0, bufferCount}, 64'd2);
            sb_check(1'b0); advance();
        end
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("drain_we", {63'd0, rfShouldWrite}, 64'd1);
            sb_check(1'b0); advance();
        end
`else
        // Guard on: the head is forced through on the 5th blocked cycle.
        pipeWriteEnable = 1'b1;
        pipeWriteIndex  = 5'd3;
        pipeWriteData   = $urandom;
        d = $urandom; offer(5'd10, d); exp_q.push_back({5'd10, d});
        settle(); sb_check(1'b0); advance();
        longResultValid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pipeWriteData = $urandom;
            settle();
            chk("starve_count", {62'd0, bufferCount}, 64'd1);
            sb_check(1'b0); advance();
        end
        pipeWriteData = $urandom;
        settle();
        chk("starve_force_idx", {59'd0, rfWriteIndex}, 64'd10);
        sb_check(1'b1); advance();
        pipeWriteData = $urandom;
        settle();
        chk("starve_after_count", {62'd0, bufferCount}, 64'd0);
        sb_check(1'b0); advance();
        idle_inputs();
`endif
        settle();
        chk("after_burst_count", {62'd0, bufferCount}, 64'd0);
        advance();

        // Drain of x7 coincides with a new issue to x7: busy bit must stay set.
        longIssueValid = 1'b1; longIssueIndex = 5'd7;
        settle(); sb_check(1'b0); advance();
        idle_inputs();
        d = $urandom; offer(5'd7, d); exp_q.push_back({5'd7, d});
        settle(); sb_check(1'b0); advance();
        idle_inputs();
        longIssueValid = 1'b1; longIssueIndex = 5'd7;
        settle();
        chk("x7_drain_we", {63'd0, rfShouldWrite}, 64'd1);
        sb_check(1'b0); advance();
        idle_inputs();
        settle();
        chk("x7_busy_kept", {32'd0, busyMask}, 64'h80);
        advance();

        // Pipe write to x0 with a buffered result: the head drains, x0 never written.
        d = $urandom; offer(5'd8, d); exp_q.push_back({5'd8, d});
        settle(); sb_check(1'b0); advance();
        idle_inputs();
        pipeWriteEnable = 1'b1; pipeWriteIndex = 5'd0; pipeWriteData = 32'hFFFF_FFFF;
        settle();
        chk("x0_pipe_head_we", {63'd0, rfShouldWrite}, 64'd1);
        sb_check(1'b0); advance();
        idle_inputs();

        // A buffered result for x0 is dropped at drain without a write.
        offer(5'd0, 32'hCAFE);
        settle(); sb_check(1'b0); advance();
        idle_inputs();
        settle();
        chk("x0_entry_count", {62'd0, bufferCount}, 64'd1);
        chk("x0_entry_no_we", {63'd0, rfShouldWrite}, 64'd0);
        advance();
        settle();
        chk("x0_entry_dropped", {62'd0, bufferCount}, 64'd0);
        advance();

        // Mid-run reset discards buffered data and busy bits.
        longIssueValid = 1'b1; longIssueIndex = 5'd20;
        offer(5'd21, 32'h5555);
        settle(); sb_check(1'b0); advance();
        idle_inputs();
        reset = 1'b1;
        advance();
        reset = 1'b0;
        settle();
        chk("rst2_count", {62'd0, bufferCount}, 64'd0);
        chk("rst2_busy", {32'd0, busyMask}, 64'd0);
        chk("rst2_we", {63'd0, rfShouldWrite}, 64'd0);
        advance();

        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
